// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default widths, output word field positions
// and the framer state encoding.
package audio_pkg;

    localparam int DATA_SIZE_DEFAULT   = 28;
    localparam int SAMPLE_BITS_DEFAULT = 24;

    localparam int CH_BIT  = 27;
    localparam int SEQ_MSB = 26;
    localparam int SEQ_LSB = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        WAIT  = 2'd3
    } framer_state_e;

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry valid/ready FIFO. A push into a full FIFO without a simultaneous
// pop is dropped and reported on the one-cycle drop output.
module sample_fifo2 #(
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             drop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        drop    = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = push_data;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = push_data;
                    count_d = 2'd2;
                end else begin
                    drop = 1'b1;
                end
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; the pop frees the slot the push needs.
                if (count_q == 2'd1) begin
                    head_d = push_data;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/i2s_sample_framer.sv
// I2S receiver: oversamples bclk/lrclk/sdata, deserializes each channel slot and
// emits {ch, seq, sample} words through a 2-entry FIFO. I2S_FRAMER_DROPCNT_EN adds drop_count.
module i2s_sample_framer
    import audio_pkg::*;
#(
    parameter int DATA_SIZE   = DATA_SIZE_DEFAULT,
    parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic                 source_valid,
    output logic [DATA_SIZE-1:0] source_data,
    input  logic                 source_ready,
    output logic                 overflow,
    output logic                 frame_err
`ifdef I2S_FRAMER_DROPCNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BITS - 1);

    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic                        bclk_s, lr_s, sd_s;
    logic                        bclk_prev_q, bclk_prev_d;
    logic                        lr_q, lr_d;
    logic                        bstb, lr_chg;

    framer_state_e               state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        ch_q, ch_d;
    logic [SAMPLE_BITS-1:0]      sample_q, sample_d;
    logic [2:0]                  seq_q, seq_d;
    logic                        overflow_q, overflow_d;
    logic                        frame_err_q, frame_err_d;
    logic                        frame_err_set;
    logic                        push, drop;
    logic [DATA_SIZE-1:0]        word;

    assign bclk_s = sync_q[SYNC_STAGES-1][2];
    assign lr_s   = sync_q[SYNC_STAGES-1][1];
    assign sd_s   = sync_q[SYNC_STAGES-1][0];
    assign bstb   = bclk_s && !bclk_prev_q;
    assign lr_chg = bstb && (lr_s != lr_q);

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {bclk, lrclk, sdata};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        bclk_prev_d   = bclk_s;
        lr_d          = bstb ? lr_s : lr_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        ch_d          = ch_q;
        sample_d      = sample_q;
        seq_d         = seq_q;
        push          = 1'b0;
        frame_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && lr_chg) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ch_d    = lr_s;
                end
            end
            SHIFT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (lr_chg) begin
                    // Short slot: drop the partial word and start the new channel.
                    frame_err_set = 1'b1;
                    cnt_d         = '0;
                    ch_d          = lr_s;
                end else if (bstb) begin
                    sample_d = {sample_q[SAMPLE_BITS-2:0], sd_s};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                push    = 1'b1;
                seq_d   = seq_q + 3'd1;
                state_d = enable ? WAIT : IDLE;
            end
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (lr_chg) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    ch_d    = lr_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word                   = '0;
        word[CH_BIT]           = ch_q;
        word[SEQ_MSB:SEQ_LSB]  = seq_q;
        word[SAMPLE_BITS-1:0]  = sample_q;
    end

    // Sticky flags: a set event in the same cycle as clear wins.
    always_comb begin
        overflow_d  = drop ? 1'b1 : (clear ? 1'b0 : overflow_q);
        frame_err_d = frame_err_set ? 1'b1 : (clear ? 1'b0 : frame_err_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
            lr_q        <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= 1'b0;
            sample_q    <= '0;
            seq_q       <= 3'd0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            bclk_prev_q <= bclk_prev_d;
            lr_q        <= lr_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            sample_q    <= sample_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    sample_fifo2 #(
        .WIDTH (DATA_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word),
        .drop      (drop),
        .out_valid (source_valid),
        .out_data  (source_data),
        .out_ready (source_ready)
    );

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

`ifdef I2S_FRAMER_DROPCNT_EN
    logic [7:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (drop) begin
            drop_count_d = (drop_count_q == 8'hFF) ? 8'hFF : drop_count_q + 8'd1;
        end else if (clear) begin
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`else
    // Without the counter, drops are recorded only by the sticky overflow flag.
`endif

endmodule

// File: tb/tb_i2s_sample_framer.sv
// Directed bench for i2s_sample_framer: drives an I2S link at clk/8 and checks
// emitted words, flags and FIFO behaviour against hand-computed values.
module tb_i2s_sample_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        bclk = 1'b0;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic        source_ready = 1'b0;
    logic        source_valid;
    logic [27:0] source_data;
    logic        overflow;
    logic        frame_err;
`ifdef I2S_FRAMER_DROPCNT_EN
    logic [7:0]  drop_count;
`endif

    int checks = 0;
    int failures = 0;
    int valid_cycles = 0;
    logic [27:0] got[$];

    always #10 clk = ~clk;

    i2s_sample_framer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .clear        (clear),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_ready (source_ready),
        .overflow     (overflow),
        .frame_err    (frame_err)
`ifdef I2S_FRAMER_DROPCNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always @(posedge clk) begin
        if (rst && source_valid) begin
            valid_cycles <= valid_cycles + 1;
            if (source_ready) got.push_back(source_data);
        end
    end

    task automatic i2s_bit(input logic lr, input logic d);
        bclk = 1'b0; lrclk = lr; sdata = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pad(input logic lr, input int n);
        for (int i = 0; i < n; i++) i2s_bit(lr, 1'b0);
    endtask

    // Delay slot carrying the lrclk change, then nbits MSB-first data bits.
    // pop_at_push pulses ready for the single clk edge that pushes this word.
    task automatic send_sample(input logic lr, input logic [23:0] s, input int nbits, input bit pop_at_push);
        i2s_bit(lr, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (pop_at_push && i == nbits - 1) begin
                bclk = 1'b0; lrclk = lr; sdata = s[23-i];
                repeat (4) @(negedge clk);
                bclk = 1'b1;
                repeat (3) @(negedge clk);
                source_ready = 1'b1;
                @(negedge clk);
                source_ready = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                i2s_bit(lr, s[23-i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bclk = ~bclk;
            @(negedge clk);
        end
        checks++; if (source_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", source_valid); end
        checks++; if (source_data !== 28'h0) begin failures++; $display("FAIL reset_data: got %h expected 0000000", source_data); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %0b expected 0", frame_err); end
        rst = 1'b1;
        enable = 1'b0;
        pad(1'b1, 3);
        checks++; if (got.size() !== 0 || source_valid !== 1'b0) begin failures++; $display("FAIL pre_capture_word: got %0d words expected 0", got.size()); end
    endtask

    task automatic test_basic();
        int vc0;
        enable = 1'b1;
        source_ready = 1'b1;
        got.delete();
        vc0 = valid_cycles;
        send_sample(1'b0, 24'hABCDEF, 24, 1'b0);
        send_sample(1'b1, 24'h123456, 24, 1'b0);
        pad(1'b1, 2);
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 2) begin failures++; $display("FAIL basic_count: got %0d expected 2", got.size()); end
        checks++; if (got[0] !== 28'h0ABCDEF) begin failures++; $display("FAIL basic_left: got %h expected 0abcdef", got[0]); end
        checks++; if (got[1] !== 28'h9123456) begin failures++; $display("FAIL basic_right: got %h expected 9123456", got[1]); end
        checks++; if (valid_cycles - vc0 !== 2) begin failures++; $display("FAIL basic_valid_cycles: got %0d expected 2", valid_cycles - vc0); end
    endtask

    task automatic test_overflow();
        source_ready = 1'b0;
        got.delete();
        send_sample(1'b0, 24'h111111, 24, 1'b0);
        send_sample(1'b1, 24'h222222, 24, 1'b0);
        send_sample(1'b0, 24'h333333, 24, 1'b0);
        pad(1'b0, 2);
        checks++; if (source_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %0b expected 1", source_valid); end
        checks++; if (source_data !== 28'h2111111) begin failures++; $display("FAIL stall_data: got %h expected 2111111", source_data); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set: got %0b expected 1", overflow); end
`ifdef I2S_FRAMER_DROPCNT_EN
        checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL drop_count_one: got %0d expected 1", drop_count); end
`endif
        source_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 2) begin failures++; $display("FAIL drain_count: got %0d expected 2", got.size()); end
        checks++; if (got[0] !== 28'h2111111) begin failures++; $display("FAIL drain_first: got %h expected 2111111", got[0]); end
        checks++; if (got[1] !== 28'hB222222) begin failures++; $display("FAIL drain_second: got %h expected b222222", got[1]); end
        got.delete();
        send_sample(1'b1, 24'h444444, 24, 1'b0);
        pad(1'b1, 2);
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 1 || got[0] !== 28'hD444444) begin failures++; $display("FAIL seq_gap_word: got %h (n=%0d) expected d444444", got[0], got.size()); end
    endtask

    task automatic test_frame_err();
        source_ready = 1'b1;
        got.delete();
        send_sample(1'b0, 24'hFFFFFF, 10, 1'b0);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL frame_err_early: got %0b expected 0", frame_err); end
        send_sample(1'b1, 24'h5A5A5A, 24, 1'b0);
        pad(1'b1, 2);
        repeat (4) @(negedge clk);
        checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL frame_err_set: got %0b expected 1", frame_err); end
        checks++; if (got.size() !== 1) begin failures++; $display("FAIL frame_word_count: got %0d expected 1", got.size()); end
        checks++; if (got[0] !== 28'hE5A5A5A) begin failures++; $display("FAIL frame_next_word: got %h expected e5a5a5a", got[0]); end
    endtask

    task automatic test_clear();
        checks++; if (overflow !== 1'b1 || frame_err !== 1'b1) begin failures++; $display("FAIL flags_held: got ovf=%0b ferr=%0b expected 1 1", overflow, frame_err); end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_overflow: got %0b expected 0", overflow); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL clear_frame_err: got %0b expected 0", frame_err); end
`ifdef I2S_FRAMER_DROPCNT_EN
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL clear_drop_count: got %0d expected 0", drop_count); end
`endif
    endtask

    task automatic test_push_pop_full();
        source_ready = 1'b0;
        got.delete();
        send_sample(1'b0, 24'hC0FFEE, 24, 1'b0);
        send_sample(1'b1, 24'hBEEF01, 24, 1'b0);
        send_sample(1'b0, 24'h13579B, 24, 1'b1);
        pad(1'b0, 2);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pushpop_overflow: got %0b expected 0", overflow); end
        checks++; if (source_data !== 28'h8BEEF01) begin failures++; $display("FAIL pushpop_head: got %h expected 8beef01", source_data); end
        source_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 3) begin failures++; $display("FAIL pushpop_count: got %0d expected 3", got.size()); end
        checks++; if (got[0] !== 28'h7C0FFEE) begin failures++; $display("FAIL pushpop_w0: got %h expected 7c0ffee", got[0]); end
        checks++; if (got[1] !== 28'h8BEEF01) begin failures++; $display("FAIL pushpop_w1: got %h expected 8beef01", got[1]); end
        checks++; if (got[2] !== 28'h113579B) begin failures++; $display("FAIL pushpop_w2: got %h expected 113579b", got[2]); end
    endtask

    task automatic test_enable();
        source_ready = 1'b1;
        got.delete();
        send_sample(1'b1, 24'hFFFFFF, 8, 1'b0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 16; i++) i2s_bit(1'b1, 1'b1);
        pad(1'b1, 2);
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 0) begin failures++; $display("FAIL enable_partial_dropped: got %0d words expected 0", got.size()); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL enable_no_frame_err: got %0b expected 0", frame_err); end
        send_sample(1'b0, 24'h2468AC, 24, 1'b0);
        pad(1'b0, 2);
        repeat (4) @(negedge clk);
        checks++; if (got.size() !== 1) begin failures++; $display("FAIL enable_resume_count: got %0d expected 1", got.size()); end
        checks++; if (got[0] !== 28'h22468AC) begin failures++; $display("FAIL enable_resume_word: got %h expected 22468ac", got[0]); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_frame_err();
        test_clear();
        test_push_pop_full();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_sample_framer.md
Name: i2s_sample_framer

Overview:
- Upstream stage of driver_interface.
- Oversamples an external I2S serial audio link (bclk, lrclk, sdata) on the system clock and deserializes each channel's sample.
- Tags each sample with channel and sequence number and emits it as a DATA_SIZE-bit word on the valid/ready source stream that driver_interface consumes.
- Includes a 2-entry output buffer, so short consumer stalls do not lose samples.

Parameters:
- DATA_SIZE, 28, output word width; must equal SAMPLE_BITS+4.
- SAMPLE_BITS, 24, audio bits captured per channel slot (MSB first).
- SYNC_STAGES, 2, flip-flop synchronizer depth on bclk/lrclk/sdata.

Ports:
- clk  in  1  system clock (50 MHz); all logic on posedge.
- rst  in  1  synchronous, active-low reset (reset when rst==0).
- enable  in  1  capture enable.
- clear  in  1  one-cycle pulse; clears sticky flags.
- bclk  in  1  I2S bit clock, asynchronous to clk, ≤ clk/8.
- lrclk  in  1  I2S word select: 0=left, 1=right; asynchronous.
- sdata  in  1  I2S serial data; asynchronous.
- source_valid  out  1  output word valid.
- source_data  out  DATA_SIZE  word: [27]=channel, [26:24]=seq, [23:0]=sample.
- source_ready  in  1  consumer accepts the word when valid&&ready.
- overflow  out  1  sticky: a completed sample was dropped because the buffer was full.
- frame_err  out  1  sticky: lrclk toggled before SAMPLE_BITS bits were captured.

Behaviour:
- Reset values: source_valid=0, source_data=0, overflow=0, frame_err=0, FSM=IDLE, seq=0, buffer empty.
- Inputs pass through SYNC_STAGES flip-flops. A bclk rising edge is detected as synchronized bclk going 0→1. All bit logic acts only on that one-cycle strobe (bstb).
- At each bstb, lrclk is sampled into lr_q. An lrclk change is lr_sync != lr_q at bstb. That slot is the I2S one-bit delay; the next bstb captures the MSB.
- FSM states:
  - IDLE: wait for enable=1 and an lrclk change at bstb → SHIFT, with cnt=0 and ch=new lrclk.
  - SHIFT: each bstb shifts sdata in and increments cnt. When cnt reaches SAMPLE_BITS → DONE.
  - DONE: raise a one-cycle push request, then → WAIT.
  - WAIT: ignore further bits; on an lrclk change at bstb → SHIFT (new ch, cnt=0).
- lrclk change in SHIFT with cnt<SAMPLE_BITS: discard the partial sample, set frame_err, re-enter SHIFT for the new channel. seq is unchanged.
- enable=0: FSM → IDLE on the next cycle and any partial sample is discarded. Buffered words still drain.
- Push: word={ch, seq, sample} is written the cycle after DONE. seq increments modulo 8 on every completed sample, pushed or dropped, so the consumer can detect gaps.
- Latency: source_valid rises 2 clk after the bstb that captured the LSB, when the buffer was empty.
- Buffer: 2-entry FIFO; source_data comes from the head register.
  - source_data/source_valid stay stable while valid&&!ready.
  - Push and pop in the same cycle while full: legal, nothing is dropped.
  - Push while full with no pop: word dropped, overflow set.
- Sticky flags clear on clear=1. If a set event and clear coincide, set wins.
- Reset asserted mid-frame: everything returns to reset values on the next clk edge.

Optional Feature:
- Macro: I2S_FRAMER_DROPCNT_EN.
- Defined: adds output drop_count[7:0]. It counts dropped samples, saturates at 8'hFF, resets to 0, and clears with clear.
- Undefined: port absent. Only the sticky overflow flag exists.

Decomposition:
- Shared package audio_pkg holds:
  - DATA_SIZE and SAMPLE_BITS defaults.
  - Field constants CH_BIT=27, SEQ_MSB=26, SEQ_LSB=24.
  - Framer FSM state enum {IDLE, SHIFT, DONE, WAIT}.
- One sub-module: sample_fifo2, the 2-entry valid/ready FIFO with push/full/drop handling, reusable elsewhere in the audio path.

Test Plan:
- Reset held low for 4 clk with bclk toggling → all outputs 0. After release, the first lrclk edge starts capture; no word is emitted before it.
- Left 24'hABCDEF then right 24'h123456, ready=1 → words 28'h0ABCDEF then 28'h9123456, each valid exactly 1 cycle.
- ready=0 and three samples sent → overflow=1. Releasing ready then yields seq 0 and 1; the next word carries seq 3.
- lrclk toggled after 10 bits → frame_err=1, no word emitted. The following full sample is emitted with ch set by the new lrclk.
- Buffer full with push and pop in the same cycle → no drop, overflow stays 0, order preserved.
- enable dropped mid-SHIFT, then restored → partial sample discarded. Capture resumes only after the next lrclk edge. clear pulse → flags 0.
